// File: rtl/batch_lifecycle_controller.sv
// rtl/batch_lifecycle_controller.sv - batch ID allocation, registration, dispatch and completion
// Producer side of the conflict-tracker batch interface.
module batch_lifecycle_controller #(
  parameter int MAX_DEPENDENCIES = 1024,
  parameter int MAX_BATCHES      = 16,
  parameter int ID_WIDTH         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_bld_valid,
  output logic                        o_bld_ready,
  input  logic [MAX_DEPENDENCIES-1:0] i_bld_read_deps,
  input  logic [MAX_DEPENDENCIES-1:0] i_bld_write_deps,
  input  logic [63:0]                 i_bld_owner_id,
  output logic                        o_new_batch_valid,
  output logic [ID_WIDTH-1:0]         o_new_batch_id,
  output logic [MAX_DEPENDENCIES-1:0] o_new_batch_read_deps,
  output logic [MAX_DEPENDENCIES-1:0] o_new_batch_write_deps,
  output logic [63:0]                 o_new_batch_owner_id,
  output logic                        o_exec_valid,
  input  logic                        i_exec_ready,
  output logic [ID_WIDTH-1:0]         o_exec_batch_id,
  output logic [63:0]                 o_exec_owner_id,
  input  logic                        i_done_valid,
  input  logic [ID_WIDTH-1:0]         i_done_id,
  output logic                        o_batch_completed,
  output logic [ID_WIDTH-1:0]         o_batch_id,
  output logic [ID_WIDTH:0]           o_active_count,
  output logic [31:0]                 o_issued_count,
  output logic [31:0]                 o_completed_count,
  output logic                        o_err_bad_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_REG, ST_DISP} fsm_e;
  typedef enum logic [1:0] {SL_FREE, SL_ALLOC, SL_OUT} slot_e;

  fsm_e                        r_state;
  slot_e                       r_slot [MAX_BATCHES];
  logic                        r_new_valid;
  logic [ID_WIDTH-1:0]         r_new_id;
  logic [MAX_DEPENDENCIES-1:0] r_read_deps;
  logic [MAX_DEPENDENCIES-1:0] r_write_deps;
  logic [63:0]                 r_owner;
  logic                        r_exec_valid;
  logic                        r_completed;
  logic [ID_WIDTH-1:0]         r_batch_id;
  logic [ID_WIDTH:0]           r_active;
  logic [31:0]                 r_issued_cnt;
  logic [31:0]                 r_completed_cnt;
  logic                        r_err;

  logic                        w_any_free;
  logic [ID_WIDTH-1:0]         w_free_id;
  logic                        w_done_ok;
  logic                        w_accept;
  logic                        w_exec_hs;

  // Scan from the top so the lowest-index FREE slot is the one left standing.
  always_comb begin
    w_any_free = 1'b0;
    w_free_id  = '0;
    for (int i = MAX_BATCHES - 1; i >= 0; i--) begin
      if (r_slot[i] == SL_FREE) begin
        w_any_free = 1'b1;
        w_free_id  = ID_WIDTH'(i);
      end
    end
  end

  // Out-of-range IDs never match any slot, so they fall through as invalid.
  always_comb begin
    w_done_ok = 1'b0;
    for (int i = 0; i < MAX_BATCHES; i++) begin
      if (i_done_valid && i_done_id == ID_WIDTH'(i) && r_slot[i] == SL_OUT) w_done_ok = 1'b1;
    end
  end

  assign o_bld_ready = !rst && (r_state == ST_IDLE) && w_any_free;
  assign w_accept    = o_bld_ready && i_bld_valid;
  assign w_exec_hs   = r_exec_valid && i_exec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_new_valid     <= 1'b0;
      r_new_id        <= '0;
      r_read_deps     <= '0;
      r_write_deps    <= '0;
      r_owner         <= '0;
      r_exec_valid    <= 1'b0;
      r_completed     <= 1'b0;
      r_batch_id      <= '0;
      r_active        <= '0;
      r_issued_cnt    <= '0;
      r_completed_cnt <= '0;
      r_err           <= 1'b0;
      for (int i = 0; i < MAX_BATCHES; i++) r_slot[i] <= SL_FREE;
    end else begin
      r_new_valid <= 1'b0;
      r_completed <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_new_id     <= w_free_id;
            r_read_deps  <= i_bld_read_deps;
            r_write_deps <= i_bld_write_deps;
            r_owner      <= i_bld_owner_id;
            r_new_valid  <= 1'b1;
            r_state      <= ST_REG;
          end
        end
        ST_REG: begin
          r_issued_cnt <= r_issued_cnt + 32'd1;
          r_exec_valid <= 1'b1;
          r_state      <= ST_DISP;
        end
        ST_DISP: begin
          if (w_exec_hs) begin
            r_exec_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Accept, dispatch and completion can never target the same slot in one cycle.
      for (int i = 0; i < MAX_BATCHES; i++) begin
        if (w_accept && w_free_id == ID_WIDTH'(i))
          r_slot[i] <= SL_ALLOC;
        else if (w_exec_hs && r_new_id == ID_WIDTH'(i))
          r_slot[i] <= SL_OUT;
        else if (w_done_ok && i_done_id == ID_WIDTH'(i))
          r_slot[i] <= SL_FREE;
      end

      if (w_done_ok) begin
        r_completed     <= 1'b1;
        r_batch_id      <= i_done_id;
        r_completed_cnt <= r_completed_cnt + 32'd1;
      end else if (i_done_valid) begin
        r_err <= 1'b1;
      end

      r_active <= r_active + (ID_WIDTH+1)'(w_accept) - (ID_WIDTH+1)'(w_done_ok);
    end
  end

  assign o_new_batch_valid      = r_new_valid;
  assign o_new_batch_id         = r_new_id;
  assign o_new_batch_read_deps  = r_read_deps;
  assign o_new_batch_write_deps = r_write_deps;
  assign o_new_batch_owner_id   = r_owner;
  assign o_exec_valid           = r_exec_valid;
  assign o_exec_batch_id        = r_new_id;
  assign o_exec_owner_id        = r_owner;
  assign o_batch_completed      = r_completed;
  assign o_batch_id             = r_batch_id;
  assign o_active_count         = r_active;
  assign o_issued_count         = r_issued_cnt;
  assign o_completed_count      = r_completed_cnt;
  assign o_err_bad_done         = r_err;

endmodule

// File: tb/tb_batch_lifecycle_controller.sv
// tb/tb_batch_lifecycle_controller.sv - scoreboard bench for batch_lifecycle_controller
module tb_batch_lifecycle_controller;

  localparam int MD = 1024;
  localparam int MB = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_bld_valid;
  logic          o_bld_ready;
  logic [MD-1:0] i_bld_read_deps;
  logic [MD-1:0] i_bld_write_deps;
  logic [63:0]   i_bld_owner_id;
  logic          o_new_batch_valid;
  logic [IW-1:0] o_new_batch_id;
  logic [MD-1:0] o_new_batch_read_deps;
  logic [MD-1:0] o_new_batch_write_deps;
  logic [63:0]   o_new_batch_owner_id;
  logic          o_exec_valid;
  logic          i_exec_ready;
  logic [IW-1:0] o_exec_batch_id;
  logic [63:0]   o_exec_owner_id;
  logic          i_done_valid;
  logic [IW-1:0] i_done_id;
  logic          o_batch_completed;
  logic [IW-1:0] o_batch_id;
  logic [IW:0]   o_active_count;
  logic [31:0]   o_issued_count;
  logic [31:0]   o_completed_count;
  logic          o_err_bad_done;

  batch_lifecycle_controller #(.MAX_DEPENDENCIES(MD), .MAX_BATCHES(MB), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .i_bld_valid(i_bld_valid), .o_bld_ready(o_bld_ready),
    .i_bld_read_deps(i_bld_read_deps), .i_bld_write_deps(i_bld_write_deps),
    .i_bld_owner_id(i_bld_owner_id),
    .o_new_batch_valid(o_new_batch_valid), .o_new_batch_id(o_new_batch_id),
    .o_new_batch_read_deps(o_new_batch_read_deps), .o_new_batch_write_deps(o_new_batch_write_deps),
    .o_new_batch_owner_id(o_new_batch_owner_id),
    .o_exec_valid(o_exec_valid), .i_exec_ready(i_exec_ready),
    .o_exec_batch_id(o_exec_batch_id), .o_exec_owner_id(o_exec_owner_id),
    .i_done_valid(i_done_valid), .i_done_id(i_done_id),
    .o_batch_completed(o_batch_completed), .o_batch_id(o_batch_id),
    .o_active_count(o_active_count), .o_issued_count(o_issued_count),
    .o_completed_count(o_completed_count), .o_err_bad_done(o_err_bad_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [63:0]   owner;
    logic [MD-1:0] rd;
    logic [MD-1:0] wr;
  } reg_t;

  reg_t          reg_q[$];
  logic [IW-1:0] cmp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [63:0]   last_owner;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MD-1:0] rand_vec();
    logic [MD-1:0] v;
    for (int i = 0; i < MD / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    reg_t e;
    if (!rst) begin
      if (o_new_batch_valid) begin
        if (reg_q.size() == 0) check("reg_unexpected", 1, 0);
        else begin
          e = reg_q.pop_front();
          check("reg_id", 64'(o_new_batch_id), 64'(e.id));
          check("reg_owner", o_new_batch_owner_id, e.owner);
          check("reg_deps", 64'(o_new_batch_read_deps == e.rd && o_new_batch_write_deps == e.wr), 1);
        end
      end
      if (o_batch_completed) begin
        if (cmp_q.size() == 0) check("cmp_unexpected", 1, 0);
        else check("cmp_id", 64'(o_batch_id), 64'(cmp_q.pop_front()));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_bld_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_bld_ready) check("ready_timeout", 0, 1);
  endtask

  // Starts and ends at a negedge; returns in the cycle after the accept edge.
  task automatic accept(input logic [IW-1:0] exp_id, input bit with_done, input logic [IW-1:0] did);
    reg_t e;
    wait_ready();
    e.id = exp_id;
    e.owner = {$urandom, $urandom};
    e.rd = rand_vec();
    e.wr = rand_vec();
    last_owner = e.owner;
    i_bld_valid = 1'b1;
    i_bld_owner_id = e.owner;
    i_bld_read_deps = e.rd;
    i_bld_write_deps = e.wr;
    reg_q.push_back(e);
    if (with_done) begin
      i_done_valid = 1'b1;
      i_done_id = did;
      cmp_q.push_back(did);
    end
    @(posedge clk);
    #1;
    i_bld_valid = 1'b0;
    i_done_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic done(input logic [IW-1:0] id, input bit good);
    i_done_valid = 1'b1;
    i_done_id = id;
    if (good) cmp_q.push_back(id);
    @(posedge clk);
    #1;
    i_done_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_bld_valid = 1'b0;
    i_bld_read_deps = '0;
    i_bld_write_deps = '0;
    i_bld_owner_id = '0;
    i_exec_ready = 1'b1;
    i_done_valid = 1'b0;
    i_done_id = '0;
    reg_q.delete();
    cmp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    i_exec_ready = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(o_bld_ready), 0);
    check("rst_exec_valid", 64'(o_exec_valid), 0);
    check("rst_active", 64'(o_active_count), 0);
    check("rst_issued", 64'(o_issued_count), 0);
    check("rst_err", 64'(o_err_bad_done), 0);
    do_reset();
    check("ready_after_rst", 64'(o_bld_ready), 1);

    // Single batch round trip
    accept(0, 0, 0);
    check("t1_nbv", 64'(o_new_batch_valid), 1);
    check("t1_active1", 64'(o_active_count), 1);
    @(negedge clk);
    check("t1_nbv_pulse", 64'(o_new_batch_valid), 0);
    check("t1_exec_valid", 64'(o_exec_valid), 1);
    check("t1_exec_id", 64'(o_exec_batch_id), 0);
    repeat (3) @(negedge clk);
    done(0, 1);
    check("t1_bc", 64'(o_batch_completed), 1);
    check("t1_active0", 64'(o_active_count), 0);
    @(negedge clk);
    check("t1_bc_pulse", 64'(o_batch_completed), 0);
    check("t1_issued", 64'(o_issued_count), 1);
    check("t1_completed", 64'(o_completed_count), 1);

    // Fill all slots, then free ID 5 and reuse it
    do_reset();
    for (int i = 0; i < MB; i++) accept(IW'(i), 0, 0);
    repeat (3) @(negedge clk);
    check("t2_full_ready", 64'(o_bld_ready), 0);
    check("t2_full_active", 64'(o_active_count), MB);
    done(5, 1);
    check("t2_active15", 64'(o_active_count), MB - 1);
    accept(5, 0, 0);
    repeat (3) @(negedge clk);
    check("t2_active16", 64'(o_active_count), MB);
    check("t2_issued", 64'(o_issued_count), MB + 1);

    // Executor backpressure
    do_reset();
    i_exec_ready = 1'b0;
    accept(0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("t3_exec_valid", 64'(o_exec_valid), 1);
      check("t3_exec_id", 64'(o_exec_batch_id), 0);
      check("t3_exec_owner", o_exec_owner_id, last_owner);
      check("t3_ready", 64'(o_bld_ready), 0);
      @(negedge clk);
    end
    i_exec_ready = 1'b1;
    @(negedge clk);
    check("t3_exec_done", 64'(o_exec_valid), 0);
    check("t3_issued", 64'(o_issued_count), 1);

    // Invalid completions: FREE slot, then ALLOCATED slot
    check("t4_err0", 64'(o_err_bad_done), 0);
    done(7, 0);
    check("t4_bc_free", 64'(o_batch_completed), 0);
    check("t4_err1", 64'(o_err_bad_done), 1);
    check("t4_cnt_free", 64'(o_completed_count), 0);
    check("t4_active_free", 64'(o_active_count), 1);
    i_exec_ready = 1'b0;
    accept(1, 0, 0);
    @(negedge clk);
    done(1, 0);
    check("t4_bc_alloc", 64'(o_batch_completed), 0);
    check("t4_cnt_alloc", 64'(o_completed_count), 0);
    check("t4_active_alloc", 64'(o_active_count), 2);
    i_exec_ready = 1'b1;
    repeat (2) @(negedge clk);
    done(0, 1);
    check("t4_bc_valid", 64'(o_batch_completed), 1);
    check("t4_active_valid", 64'(o_active_count), 1);

    // Accept on the same edge as a valid completion of another ID
    accept(0, 1, 1);
    check("t5_nbv", 64'(o_new_batch_valid), 1);
    check("t5_bc", 64'(o_batch_completed), 1);
    check("t5_active", 64'(o_active_count), 1);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", 64'(o_err_bad_done), 1);

    // Reset asserted while dispatching
    do_reset();
    i_exec_ready = 1'b0;
    accept(0, 0, 0);
    @(negedge clk);
    check("t6_disp", 64'(o_exec_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_exec", 64'(o_exec_valid), 0);
    check("t6_rst_active", 64'(o_active_count), 0);
    check("t6_rst_issued", 64'(o_issued_count), 0);
    check("t6_rst_ready", 64'(o_bld_ready), 0);
    reg_q.delete();
    cmp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    i_exec_ready = 1'b1;
    @(negedge clk);
    check("t6_ready", 64'(o_bld_ready), 1);
    accept(0, 0, 0);
    repeat (3) @(negedge clk);

    check("reg_q_drained", 64'(reg_q.size()), 0);
    check("cmp_q_drained", 64'(cmp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
